// File: rtl/updown_mod_counter.sv
// updown_mod_counter
// Up/down counter over 0..MODULUS-1 with wrap or saturate behaviour at the
// range ends, synchronous parallel load with range check, a combinational
// terminal-count flag and registered wrap / load-error pulses.
module updown_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Top of range built at WIDTH bits so MODULUS = 2**WIDTH gives all ones
  // rather than a truncated 32-bit value.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  // The load range check needs one extra bit to represent MODULUS = 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam bit               SAT_EN  = (SAT != 0);

  logic             at_top;
  logic             at_bot;
  logic             boundary;
  logic             load_ok;
  logic [WIDTH-1:0] count_nxt;

  assign at_top   = (count == CNT_MAX);
  assign at_bot   = (count == '0);
  assign boundary = up_dn ? at_top : at_bot;
  assign load_ok  = ({1'b0, load_val} < MOD_EXT);

  // Terminal count flags the cycle whose edge performs the boundary action.
  assign tc = en & ~load & boundary;

  // Next count: load beats enable, enable beats hold.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_ok ? load_val : '0;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) count_nxt = SAT_EN ? count : '0;
        else        count_nxt = count + WIDTH'(1);
      end else begin
        if (at_bot) count_nxt = SAT_EN ? count : CNT_MAX;
        else        count_nxt = count - WIDTH'(1);
      end
    end
  end

  // Count register and one-cycle event pulses; reset clears all of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= tc;
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a wrap-mode and a saturate-mode
// instance (WIDTH=4, MODULUS=10) and a full-range instance (WIDTH=3, MODULUS=8).
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // wrap-mode instance
  logic       m_en = 0, m_up = 1, m_load = 0;
  logic [3:0] m_lv = '0;
  logic [3:0] m_count;
  logic       m_tc, m_wrap, m_lerr;

  // saturate-mode instance
  logic       s_en = 0, s_up = 1, s_load = 0;
  logic [3:0] s_lv = '0;
  logic [3:0] s_count;
  logic       s_tc, s_wrap, s_lerr;

  // full-range instance
  logic       f_en = 0, f_up = 1, f_load = 0;
  logic [2:0] f_lv = '0;
  logic [2:0] f_count;
  logic       f_tc, f_wrap, f_lerr;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .en(m_en), .up_dn(m_up), .load(m_load), .load_val(m_lv),
    .count(m_count), .tc(m_tc), .wrap(m_wrap), .load_err(m_lerr));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .load(s_load), .load_val(s_lv),
    .count(s_count), .tc(s_tc), .wrap(s_wrap), .load_err(s_lerr));

  updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SAT(0)) u_full (
    .clk(clk), .rst(rst), .en(f_en), .up_dn(f_up), .load(f_load), .load_val(f_lv),
    .count(f_count), .tc(f_tc), .wrap(f_wrap), .load_err(f_lerr));

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_dn [6] = '{3, 2, 1, 0, 9, 8};

  initial begin
    // 1. reset, then up-count through the wrap, then asynchronous reset
    repeat (3) tick();
    chk("rst_count", 32'(m_count), 0);
    chk("rst_wrap", 32'(m_wrap), 0);
    chk("rst_lerr", 32'(m_lerr), 0);
    #2 rst = 1'b1;
    m_en = 1; m_up = 1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up_count_%0d", i), 32'(m_count), i % 10);
      chk($sformatf("up_tc_%0d", i), 32'(m_tc), (i % 10 == 9) ? 1 : 0);
      chk($sformatf("up_wrap_%0d", i), 32'(m_wrap), (i == 10) ? 1 : 0);
      tick();
    end
    chk("up_final", 32'(m_count), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(m_count), 0);
    chk("async_rst_wrap", 32'(m_wrap), 0);
    tick();
    #2 rst = 1'b1;
    m_en = 0;
    tick();
    chk("post_rst_hold", 32'(m_count), 0);

    // 2. down count from 3 through the wrap to 9
    m_load = 1; m_lv = 4'd3;
    tick();
    m_load = 0; m_en = 1; m_up = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("dn_count_%0d", i), 32'(m_count), exp_dn[i]);
      chk($sformatf("dn_wrap_%0d", i), 32'(m_wrap), (i == 4) ? 1 : 0);
      if (i < 5) begin
        chk($sformatf("dn_tc_%0d", i), 32'(m_tc), (i == 3) ? 1 : 0);
        tick();
      end
    end

    // 3. load priority over enable, range check at the boundary
    m_load = 1; m_en = 1; m_up = 1; m_lv = 4'd7;
    chk("load_tc_masked", 32'(m_tc), 0);
    tick();
    chk("load7_count", 32'(m_count), 7);
    chk("load7_lerr", 32'(m_lerr), 0);
    m_lv = 4'd12;
    tick();
    chk("load12_count", 32'(m_count), 0);
    chk("load12_lerr", 32'(m_lerr), 1);
    m_lv = 4'd9;
    tick();
    chk("load9_count", 32'(m_count), 9);
    chk("load9_lerr", 32'(m_lerr), 0);
    chk("load9_tc_masked", 32'(m_tc), 0);
    m_lv = 4'd10;
    tick();
    chk("load10_count", 32'(m_count), 0);
    chk("load10_lerr", 32'(m_lerr), 1);
    chk("load10_wrap", 32'(m_wrap), 0);
    m_load = 0; m_en = 0;
    tick();
    chk("lerr_clear", 32'(m_lerr), 0);
    chk("hold_count", 32'(m_count), 0);

    // 4. saturate mode
    s_load = 1; s_lv = 4'd8;
    tick();
    s_load = 0; s_en = 1; s_up = 1;
    tick();
    chk("sat_up_1", 32'(s_count), 9);
    chk("sat_up_wrap_1", 32'(s_wrap), 0);
    chk("sat_tc", 32'(s_tc), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("sat_up_%0d", i), 32'(s_count), 9);
      chk($sformatf("sat_up_wrap_%0d", i), 32'(s_wrap), 1);
    end
    s_load = 1; s_lv = 4'd1;
    tick();
    s_load = 0; s_up = 0;
    tick();
    chk("sat_dn_1", 32'(s_count), 0);
    chk("sat_dn_wrap_1", 32'(s_wrap), 0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      chk($sformatf("sat_dn_%0d", i), 32'(s_count), 0);
      chk($sformatf("sat_dn_wrap_%0d", i), 32'(s_wrap), 1);
    end
    s_en = 0;

    // 5. enable gating and direction flip
    m_load = 1; m_lv = 4'd5;
    tick();
    m_load = 0; m_en = 0; m_up = 1;
    tick();
    chk("gate_hold_5", 32'(m_count), 5);
    m_en = 1; m_up = 0;
    tick();
    chk("flip_4", 32'(m_count), 4);
    m_en = 0;
    tick();
    chk("gate_hold_4", 32'(m_count), 4);
    m_en = 1;
    tick();
    chk("flip_3", 32'(m_count), 3);
    m_load = 1; m_lv = 4'd9;
    tick();
    m_load = 0; m_en = 0; m_up = 1;
    chk("tc_gated", 32'(m_tc), 0);
    tick();
    chk("gated_at_top", 32'(m_count), 9);
    chk("gated_no_wrap", 32'(m_wrap), 0);
    m_en = 1;
    #1;
    chk("tc_enabled", 32'(m_tc), 1);
    m_en = 0;

    // 6. full-range modulus
    chk("full_start", 32'(f_count), 0);
    f_en = 1; f_up = 1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("full_count_%0d", i), 32'(f_count), i % 8);
      chk($sformatf("full_tc_%0d", i), 32'(f_tc), (i == 7) ? 1 : 0);
      chk($sformatf("full_wrap_%0d", i), 32'(f_wrap), (i == 8) ? 1 : 0);
      tick();
    end
    chk("full_final", 32'(f_count), 2);
    chk("full_lerr", 32'(f_lerr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
